// File: rtl/flt_pkg.sv
// Shared types and constants for the sequential floating-point units.
package flt_pkg;

    // Default (half-precision) geometry
    localparam int DEF_EXP_W = 5;
    localparam int DEF_MAN_W = 10;
    localparam int BIAS      = 2**(DEF_EXP_W-1) - 1;
    localparam int EXP_MAX   = 2**DEF_EXP_W - 1;
    // Working mantissa: hidden, stored mantissa, guard, round, sticky
    localparam int WM_W      = DEF_MAN_W + 4;

    typedef enum logic [2:0] {
        IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
    } state_t;

    typedef struct packed {
        logic                 sign;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_MAN_W-1:0] mant;
    } flt_t;

endpackage

// File: rtl/flt_round.sv
// Combinational mantissa rounding: round-to-nearest-even or truncate.
module flt_round #(
    parameter int MAN_W  = 10,
    parameter int RND_EN = 1
) (
    input  logic [MAN_W:0]   mant_in,   // hidden bit + stored mantissa
    input  logic             g,
    input  logic             r,
    input  logic             s,
    output logic [MAN_W+1:0] mant_out,  // extra msb catches the rounding carry
    output logic             inexact
);
    logic inc;

    // Round up above half, or at exactly half when the lsb is odd
    always_comb begin
        inc      = (RND_EN != 0) && g && (r || s || mant_in[0]);
        mant_out = {1'b0, mant_in} + {{(MAN_W+1){1'b0}}, inc};
        inexact  = g | r | s;
    end
endmodule

// File: rtl/flt_add_seq.sv
// Multi-cycle floating-point add/subtract with start/done handshake.
module flt_add_seq
    import flt_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MAN_W  = DEF_MAN_W,
    parameter int RND_EN = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     op,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     done,
    output logic                     busy,
    output logic                     ovf,
    output logic                     zero,
    output logic                     inexact
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int WM = WM_W - DEF_MAN_W + MAN_W;   // hidden, mant, G, R, S
    localparam int EW = EXP_W + 2;                  // signed exponent headroom
    localparam logic signed [EW-1:0] EX_ONE = EW'(1);
    localparam logic signed [EW-1:0] EX_TOP = EW'((1 << EXP_W) - 1);
    localparam logic [EW-1:0]        D_ONE  = EW'(1);
    localparam logic [EW-1:0]        D_COLL = EW'(MAN_W + 3);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
    } fp_t;

    state_t               state, state_nx;
    fp_t                  a_r, b_r, big, sml, r_res;
    logic                 sa, sb, r_ovf, r_zero, r_inx;
    logic                 a_zero, b_zero, a_inf, b_inf, swap, accept;
    logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
    logic [EXP_W-1:0]     e_diff;
    logic [WM-1:0]        ma, mb;
    logic [WM:0]          sum;
    logic signed [EW-1:0] ex, ex_r;
    logic [EW-1:0]        d;
    logic [MAN_W+1:0]     rnd_m;
    logic [MAN_W-1:0]     man_r;
    logic                 rnd_inx;

    // A new request is taken when idle, or once the previous result is out
    assign accept = start && (state == IDLE || (state == DONE && done));

    // Classify captured operands and order them so |big| >= |sml|
    always_comb begin
        a_zero = (a_r.exp == '0);
        b_zero = (b_r.exp == '0);
        a_inf  = &a_r.exp;
        b_inf  = &b_r.exp;
        mag_a  = a_zero ? '0 : {a_r.exp, a_r.mant};
        mag_b  = b_zero ? '0 : {b_r.exp, b_r.mant};
        swap   = mag_b > mag_a;
        big    = swap ? b_r : a_r;
        sml    = swap ? a_r : b_r;
        e_diff = big.exp - sml.exp;
    end

    flt_round #(.MAN_W(MAN_W), .RND_EN(RND_EN)) u_round (
        .mant_in  (sum[WM-1:3]),
        .g        (sum[2]),
        .r        (sum[1]),
        .s        (sum[0]),
        .mant_out (rnd_m),
        .inexact  (rnd_inx)
    );

    // Renormalise after a rounding carry
    always_comb begin
        ex_r  = rnd_m[MAN_W+1] ? ex + EX_ONE : ex;
        man_r = rnd_m[MAN_W+1] ? rnd_m[MAN_W:1] : rnd_m[MAN_W-1:0];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (accept) state_nx = UNPACK;
            UNPACK: begin
                if (a_inf || b_inf)     state_nx = DONE;
                else if (e_diff == '0)  state_nx = ADD;
                else                    state_nx = ALIGN;
            end
            ALIGN:  if (d > D_COLL || d == D_ONE) state_nx = ADD;
            ADD:    state_nx = NORM;
            NORM: begin
                if (sum[WM])             state_nx = ROUND;
                else if (sum == '0)      state_nx = DONE;
                else if (!sum[WM-1]) begin
                    if (ex <= EX_ONE)    state_nx = DONE;
                end
                else                     state_nx = ROUND;
            end
            ROUND:  state_nx = DONE;
            DONE:   if (accept) state_nx = UNPACK;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath, staged result and handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r <= '0;  b_r <= '0;  sa <= 1'b0; sb <= 1'b0;
            ma <= '0;   mb <= '0;   sum <= '0;  ex <= '0;  d <= '0;
            r_res <= '0; r_ovf <= 1'b0; r_zero <= 1'b0; r_inx <= 1'b0;
            result <= '0; done <= 1'b0; busy <= 1'b0;
            ovf <= 1'b0; zero <= 1'b0; inexact <= 1'b0;
        end else begin
            if (accept) begin
                a_r     <= a;
                b_r     <= {b[W-1] ^ op, b[W-2:0]};
                busy    <= 1'b1;
                done    <= 1'b0;
                ovf     <= 1'b0;
                zero    <= 1'b0;
                inexact <= 1'b0;
            end
            case (state)
                UNPACK: begin
                    sa <= big.sign;
                    sb <= sml.sign;
                    ma <= (big.exp != '0) ? {1'b1, big.mant, 3'b000} : '0;
                    mb <= (sml.exp != '0) ? {1'b1, sml.mant, 3'b000} : '0;
                    ex <= {2'b00, big.exp};
                    d  <= {2'b00, e_diff};
                    // Infinity short-circuits; opposite infinities saturate to +inf
                    r_res.exp  <= '1;
                    r_res.mant <= '0;
                    r_res.sign <= (a_inf && b_inf && (a_r.sign != b_r.sign)) ? 1'b0 :
                                  (a_inf ? a_r.sign : b_r.sign);
                    r_ovf  <= a_inf && b_inf && (a_r.sign != b_r.sign);
                    r_zero <= 1'b0;
                    r_inx  <= 1'b0;
                end
                ALIGN: begin
                    if (d > D_COLL) begin
                        mb <= {{(WM-1){1'b0}}, |mb};
                        d  <= '0;
                    end else begin
                        mb <= {1'b0, mb[WM-1:2], mb[1] | mb[0]};
                        d  <= d - D_ONE;
                    end
                end
                ADD: sum <= (sa ^ sb) ? {1'b0, ma} - {1'b0, mb} : {1'b0, ma} + {1'b0, mb};
                NORM: begin
                    if (sum[WM]) begin
                        sum <= {1'b0, sum[WM:2], sum[1] | sum[0]};
                        ex  <= ex + EX_ONE;
                    end else if (sum == '0) begin
                        r_res <= '0; r_ovf <= 1'b0; r_zero <= 1'b1; r_inx <= 1'b0;
                    end else if (!sum[WM-1]) begin
                        if (ex <= EX_ONE) begin
                            // Would go subnormal: flush to +0
                            r_res <= '0; r_ovf <= 1'b0; r_zero <= 1'b1; r_inx <= 1'b1;
                        end else begin
                            sum <= {sum[WM-1:0], 1'b0};
                            ex  <= ex - EX_ONE;
                        end
                    end
                end
                ROUND: begin
                    r_res.sign <= sa;
                    r_zero     <= 1'b0;
                    r_inx      <= rnd_inx;
                    if (ex_r >= EX_TOP) begin
                        r_res.exp  <= '1;
                        r_res.mant <= '0;
                        r_ovf      <= 1'b1;
                    end else begin
                        r_res.exp  <= ex_r[EXP_W-1:0];
                        r_res.mant <= man_r;
                        r_ovf      <= 1'b0;
                    end
                end
                DONE: begin
                    if (!done) begin
                        result  <= r_res;
                        ovf     <= r_ovf;
                        zero    <= r_zero;
                        inexact <= r_inx;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_flt_add_seq.sv
// Scoreboard bench for flt_add_seq: one RNE instance, one truncating instance.
module tb_flt_add_seq;
    import flt_pkg::*;

    localparam int LAT_MAX = 5 + (DEF_MAN_W + 3) + (DEF_MAN_W + 2);

    typedef struct {
        string       nm;
        logic [15:0] res;
        logic        ovf;
        logic        zero;
        logic        inx;
        int          lat;   // exact latency, 0 = only the upper bound applies
        int          t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [15:0] a, b, res0, res1;
    logic        done0, done1, busy0, busy1, ovf0, ovf1, zero0, zero1, inx0, inx1;
    logic        done0_q = 1'b0, done1_q = 1'b0;
    int          n_chk = 0, n_fail = 0, cyc = 0;
    exp_t        q0[$], q1[$];

    flt_add_seq #(.EXP_W(5), .MAN_W(10), .RND_EN(1)) u_rne (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(res0), .done(done0), .busy(busy0), .ovf(ovf0), .zero(zero0), .inexact(inx0));

    flt_add_seq #(.EXP_W(5), .MAN_W(10), .RND_EN(0)) u_trn (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(res1), .done(done1), .busy(busy1), .ovf(ovf1), .zero(zero1), .inexact(inx1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic check_resp(input string tag, input exp_t e, input logic [15:0] r,
                              input logic o, input logic z, input logic x);
        chk({tag, " ", e.nm, " result"}, 32'(r), 32'(e.res));
        chk({tag, " ", e.nm, " ovf"}, 32'(o), 32'(e.ovf));
        chk({tag, " ", e.nm, " zero"}, 32'(z), 32'(e.zero));
        chk({tag, " ", e.nm, " inexact"}, 32'(x), 32'(e.inx));
        if (e.lat > 0) chk({tag, " ", e.nm, " latency"}, 32'(cyc - e.t0), 32'(e.lat));
        chk({tag, " ", e.nm, " latency bound"}, 32'((cyc - e.t0) <= LAT_MAX), 32'(1));
    endtask

    // Monitor: compare on each rising edge of done
    always @(negedge clk) begin
        done0_q <= done0;
        done1_q <= done1;
        if (done0 && !done0_q) begin
            chk("rne done has pending entry", 32'(q0.size() > 0), 32'(1));
            if (q0.size() > 0) check_resp("rne", q0.pop_front(), res0, ovf0, zero0, inx0);
        end
        if (done1 && !done1_q) begin
            chk("trn done has pending entry", 32'(q1.size() > 0), 32'(1));
            if (q1.size() > 0) check_resp("trn", q1.pop_front(), res1, ovf1, zero1, inx1);
        end
    end

    task automatic push_start(input string nm, input logic [15:0] ia, input logic [15:0] ib,
                              input logic iop, input logic [15:0] r_rne, input logic [15:0] r_trn,
                              input logic f_ovf, input logic f_zero, input logic f_inx, input int lat);
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; op = iop; start = 1'b1;
        e.nm = nm; e.res = r_rne; e.ovf = f_ovf; e.zero = f_zero; e.inx = f_inx;
        e.lat = lat; e.t0 = cyc + 1;
        q0.push_back(e);
        e.res = r_trn;
        q1.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("responses drained in time", 32'(q0.size() + q1.size()), 32'(0));
        q0.delete();
        q1.delete();
    endtask

    task automatic issue(input string nm, input logic [15:0] ia, input logic [15:0] ib,
                         input logic iop, input logic [15:0] r_rne, input logic [15:0] r_trn,
                         input logic f_ovf, input logic f_zero, input logic f_inx, input int lat);
        push_start(nm, ia, ib, iop, r_rne, r_trn, f_ovf, f_zero, f_inx, lat);
        wait_drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a_sw, b_sw, r_sw;
        reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset result", 32'(res0), 32'(0));
        chk("reset done", 32'(done0), 32'(0));
        chk("reset busy", 32'(busy0), 32'(0));
        chk("reset flags", 32'({ovf0, zero0, inx0}), 32'(0));
        chk("reset trn outputs", 32'({res1, done1, busy1, ovf1, zero1, inx1}), 32'(0));
        reset = 1'b1;

        //    name               a        b        op  rne      trn      ovf  zero inx  lat
        issue("1A04+1A04",       16'h1A04, 16'h1A04, 0, 16'h1E04, 16'h1E04, 0, 0, 0, 5);
        issue("3C00-3800",       16'h3C00, 16'h3800, 1, 16'h3800, 16'h3800, 0, 0, 0, 7);
        issue("3C00+1000 tie",   16'h3C00, 16'h1000, 0, 16'h3C00, 16'h3C00, 0, 0, 1, 16);
        issue("3C01+1000",       16'h3C01, 16'h1000, 0, 16'h3C02, 16'h3C01, 0, 0, 1, 16);
        issue("3C00-3C00",       16'h3C00, 16'h3C00, 1, 16'h0000, 16'h0000, 0, 1, 0, 0);
        issue("BC00+3C00",       16'hBC00, 16'h3C00, 0, 16'h0000, 16'h0000, 0, 1, 0, 0);
        issue("7BFF+7BFF",       16'h7BFF, 16'h7BFF, 0, 16'h7C00, 16'h7C00, 1, 0, 0, 5);
        issue("7C00+3C00",       16'h7C00, 16'h3C00, 0, 16'h7C00, 16'h7C00, 0, 0, 0, 0);
        issue("5000+0400",       16'h5000, 16'h0400, 0, 16'h5000, 16'h5000, 0, 0, 1, 6);

        // Exponent-difference sweep: 2^10 + 2^(10-d)
        a_sw = 16'((BIAS + 10) << DEF_MAN_W);
        for (int dd = 0; dd <= 20; dd++) begin
            b_sw = 16'((BIAS + 10 - dd) << DEF_MAN_W);
            if (dd == 0)       r_sw = 16'h6800;
            else if (dd <= 10) r_sw = 16'h6400 | 16'(1 << (10 - dd));
            else               r_sw = 16'h6400;
            issue($sformatf("sweep d=%0d", dd), a_sw, b_sw, 0, r_sw, r_sw, 0, 0, dd >= 11,
                  (dd == 0) ? 5 : 5 + ((dd > 13) ? 1 : dd));
        end

        // Start pulsed while aligning must be ignored
        push_start("3C00+1000 busy start", 16'h3C00, 16'h1000, 0, 16'h3C00, 16'h3C00, 0, 0, 1, 16);
        repeat (3) @(negedge clk);
        chk("busy during ALIGN", 32'(busy0), 32'(1));
        a = 16'h7BFF; b = 16'h7BFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        wait_drain();
        repeat (40) @(negedge clk);
        chk("result held after ignored start", 32'(res0), 32'(16'h3C00));

        // Abort mid-normalisation (1-ulp difference needs many left shifts)
        @(negedge clk);
        a = 16'h3C01; b = 16'h3C00; op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy during NORM", 32'(busy0), 32'(1));
        reset = 1'b0;
        #1;
        chk("abort result", 32'(res0), 32'(0));
        chk("abort done/busy", 32'({done0, busy0}), 32'(0));
        chk("abort flags", 32'({ovf0, zero0, inx0}), 32'(0));
        chk("abort trn outputs", 32'({res1, done1, busy1, ovf1, zero1, inx1}), 32'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue("1A04+1A04 after reset", 16'h1A04, 16'h1A04, 0, 16'h1E04, 16'h1E04, 0, 0, 0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
